// File: rtl/runtime_log.sv
// Runtime-value capture FIFO (first-word-fall-through) with overflow, running-max and capture statistics.
// One-cycle write latency; a full FIFO drops captures unless a pop happens in the same cycle.
module runtime_log #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           ctr_val,
    input  logic                       capture_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic [WIDTH-1:0]           max_val,
    input  logic                       clr_max,
    output logic [15:0]                cap_total
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [15:0]      total_q, total_d;

    logic pop;
    logic push;
    logic drop;

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign push     = capture_en & ((count_q < DEPTH_C) | pop);
    assign drop     = capture_en & ~push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_comb begin
        max_d = max_q;
        if (capture_en) begin
            if (clr_max)             max_d = ctr_val;
            else if (ctr_val > max_q) max_d = ctr_val;
        end else if (clr_max) begin
            max_d = '0;
        end
    end

    always_comb begin
        total_d = total_q;
        if (capture_en && (total_q != 16'hFFFF)) total_d = total_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            max_q    <= '0;
            total_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            max_q    <= max_d;
            total_q  <= total_d;
        end
    end

    // Storage carries no reset; count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ctr_val;
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign max_val   = max_q;
    assign cap_total = total_q;

endmodule

// File: doc/runtime_log.md
RUNTIME_LOG -- requirements
Module: runtime_log

Interface
REQ-001 Parameter WIDTH, default 32, bit width of a captured runtime value (matches word_type).
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 ctr_val  input  WIDTH  runtime value from the upstream runtime counter.
REQ-006 capture_en  input  1  single-cycle strobe: log ctr_val this cycle.
REQ-007 rd_data  output  WIDTH  oldest logged value (first-word-fall-through).
REQ-008 rd_valid  output  1  FIFO non-empty.
REQ-009 rd_ready  input  1  consumer accepts rd_data when rd_valid is high.
REQ-010 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-011 overflow  output  1  sticky flag: a capture was dropped.
REQ-012 clr_ovf  input  1  clears overflow.
REQ-013 max_val  output  WIDTH  largest ctr_val seen on any capture_en since last clear.
REQ-014 clr_max  input  1  clears max_val.
REQ-015 cap_total  output  16  number of capture_en strobes seen, saturating.

Function
REQ-016 Pop occurs in a cycle when rd_valid and rd_ready are both high; head advances at the next posedge.
REQ-017 Push is accepted in a cycle when capture_en is high and (count < DEPTH or a pop occurs in the same cycle).
REQ-018 An accepted push writes ctr_val as sampled at that posedge; no added latency beyond one register stage.
REQ-019 rd_valid = (count != 0); rd_data = entry at read pointer, combinationally from storage, with no bubble.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance; this holds both when count == DEPTH and when 0 < count < DEPTH.
REQ-021 Push into an empty FIFO: rd_valid and rd_data are valid on the cycle after the push posedge.
REQ-022 Pop when empty is impossible, because rd_ready is ignored while rd_valid is low.
REQ-023 Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; count alone distinguishes full from empty.
REQ-024 A capture_en that is not accepted (full, no pop) is dropped; storage and pointers are unchanged and overflow is set at the next posedge.
REQ-025 clr_ovf clears overflow at the next posedge; on a simultaneous drop and clr_ovf, set wins (overflow = 1).
REQ-026 On every capture_en, accepted or dropped: max_val <= (ctr_val > max_val) ? ctr_val : max_val, unsigned compare.
REQ-027 clr_max sets max_val to 0; on simultaneous clr_max and capture_en, max_val <= ctr_val.
REQ-028 cap_total increments by 1 on every capture_en, saturates at 16'hFFFF, and is not cleared except by reset.
REQ-029 rd_data content is undefined while rd_valid is low; the bench SHALL NOT check it then.

Reset
REQ-030 rst low asynchronously forces: pointers = 0, count = 0, rd_valid = 0, overflow = 0, max_val = 0, cap_total = 0.
REQ-031 FIFO storage is not reset.
REQ-032 Reset asserted mid-operation discards all entries; the first cycle after release behaves as empty.
REQ-033 Inputs are ignored while rst is low.

Verification
REQ-034 Reset then capture_en with ctr_val = 5, 9, 3 on consecutive cycles, rd_ready = 0 -> count = 3, rd_data = 5, max_val = 9, cap_total = 3.
REQ-035 Fill to DEPTH = 4 (values 1..4), then capture 7 with rd_ready = 0 -> count = 4, overflow = 1, 7 absent, max_val = 7; drain gives 1, 2, 3, 4.
REQ-036 Full FIFO, capture 8 with rd_ready = 1 in the same cycle -> 1 popped, 8 accepted, count stays 4, overflow stays 0; drain gives 2, 3, 4, 8.
REQ-037 Ten push/pop cycles with continuous rd_ready and values 10..19 -> outputs 10..19 in order across pointer wrap, count never exceeds 1.
REQ-038 Drop and clr_ovf in the same cycle -> overflow = 1; clr_ovf alone next cycle -> overflow = 0. clr_max with capture of 6 while max_val = 9 -> max_val = 6.
REQ-039 Assert rst low asynchronously between posedges while count = 3 -> rd_valid = 0 and count = 0 immediately; cap_total = 0 after release.
